// File: rtl/ddr_burst_pkg.sv
// Shared types and constants for the DDR burst controller.
package ddr_burst_pkg;

  localparam int LEN_W      = 8;
  localparam int WORD_SHIFT = 3;   // 64-bit words: byte address >> 3

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE
  } state_t;

endpackage

// File: rtl/burst_counter.sv
// Remaining-beat down-counter with a terminal-count flag on the final beat.
module burst_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] remain,
  output logic         last
);

  // Load wins over decrement; a decrement on the last beat leaves the counter at 0.
  always_ff @(posedge clock) begin
    if (reset)
      remain <= '0;
    else if (load)
      remain <= load_val;
    else if (dec)
      remain <= remain - W'(1);
  end

  // Terminal count: the beat being counted now is the final one.
  always_comb begin
    last = (remain == W'(1));
  end

endmodule

// File: rtl/ddr_burst_ctrl.sv
// Burst tracker between the memory arbiter and the DDR port. All data and
// handshake paths are combinational; the FSM only gates them and latches
// address/length for the duration of a burst.
//
// state | meaning
// IDLE  | no burst open; command and first write beat pass through live
// READ  | read issued, waiting for the remaining ddr_valid beats
// WRITE | first write beat taken, streaming the remaining beats
module ddr_burst_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = ddr_burst_pkg::LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_rd,
  input  logic              in_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_mask,
  input  logic [63:0]       in_din,
  input  logic [LEN_W-1:0]  in_burstLength,
  output logic [63:0]       in_dout,
  output logic              in_wait_n,
  output logic              in_valid,
  output logic              in_burstDone,
  output logic              ddr_rd,
  output logic              ddr_wr,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [7:0]        ddr_mask,
  output logic [63:0]       ddr_din,
  output logic [LEN_W-1:0]  ddr_burstLength,
  input  logic [63:0]       ddr_dout,
  input  logic              ddr_wait_n,
  input  logic              ddr_valid,
  output logic              busy,
  output logic              err
);

  import ddr_burst_pkg::*;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   remain;
  logic               last;
  logic               cnt_load;
  logic [LEN_W-1:0]   cnt_val;
  logic               cnt_dec;
  logic               latch_en;

  burst_counter #(.W(LEN_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .remain   (remain),
    .last     (last)
  );

  // Data paths never depend on state.
  assign in_dout  = ddr_dout;
  assign ddr_din  = in_din;
  assign ddr_mask = in_mask;
  assign busy     = (state != IDLE);

  // Next state, handshake gating and counter control.
  always_comb begin
    len_eff      = (in_burstLength == '0) ? ONE : in_burstLength;
    state_nxt    = state;
    ddr_rd       = 1'b0;
    ddr_wr       = 1'b0;
    in_wait_n    = ddr_wait_n;
    in_valid     = 1'b0;
    in_burstDone = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = len_eff;
    cnt_dec      = 1'b0;
    latch_en     = 1'b0;
    case (state)
      IDLE: begin
        ddr_rd = in_rd;
        ddr_wr = in_wr & ~in_rd;
        if (in_rd && ddr_wait_n) begin
          latch_en  = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = READ;
        end else if (in_wr && ddr_wait_n) begin
          if (len_eff == ONE) begin
            // Single-beat write finishes without leaving IDLE.
            in_burstDone = 1'b1;
          end else begin
            latch_en  = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = len_eff - ONE;
            state_nxt = WRITE;
          end
        end
      end
      READ: begin
        in_wait_n = 1'b0;
        in_valid  = ddr_valid;
        if (ddr_valid) begin
          cnt_dec = 1'b1;
          if (last) begin
            in_burstDone = 1'b1;
            state_nxt    = IDLE;
          end
        end
      end
      WRITE: begin
        ddr_wr = in_wr;
        if (in_wr && ddr_wait_n) begin
          cnt_dec = 1'b1;
          if (last) begin
            in_burstDone = 1'b1;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and length are live in IDLE and held from the latch while a burst is open.
  always_comb begin
    if (state == IDLE) begin
      ddr_addr        = in_addr >> WORD_SHIFT;
      ddr_burstLength = len_eff;
    end else begin
      ddr_addr        = addr_q >> WORD_SHIFT;
      ddr_burstLength = len_q;
    end
  end

  // State register plus the sticky stray-read-data flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ddr_valid && state != READ)
        err <= 1'b1;
    end
  end

  // Capture command address/length on the accepted first beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
    end else if (latch_en) begin
      addr_q <= in_addr;
      len_q  <= len_eff;
    end
  end

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
module tb_ddr_burst_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_rd, in_wr;
  logic [31:0] in_addr;
  logic [7:0]  in_mask;
  logic [63:0] in_din;
  logic [7:0]  in_burstLength;
  logic [63:0] in_dout;
  logic        in_wait_n, in_valid, in_burstDone;
  logic        ddr_rd, ddr_wr;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_mask;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_burstLength;
  logic [63:0] ddr_dout;
  logic        ddr_wait_n, ddr_valid;
  logic        busy, err;

  always #5 clock = ~clock;

  ddr_burst_ctrl dut (
    .clock(clock), .reset(reset),
    .in_rd(in_rd), .in_wr(in_wr), .in_addr(in_addr), .in_mask(in_mask),
    .in_din(in_din), .in_burstLength(in_burstLength), .in_dout(in_dout),
    .in_wait_n(in_wait_n), .in_valid(in_valid), .in_burstDone(in_burstDone),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_mask(ddr_mask),
    .ddr_din(ddr_din), .ddr_burstLength(ddr_burstLength), .ddr_dout(ddr_dout),
    .ddr_wait_n(ddr_wait_n), .ddr_valid(ddr_valid), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: beats still owed by the open burst (0 = none).
  int          m_left = 0;
  bit          m_is_rd = 0;
  logic [31:0] m_addr = '0;
  int          m_len = 0;
  bit          m_err = 0;

  int cnt_rdcmd, cnt_valid, cnt_done, cnt_wracc;

  typedef struct {
    logic        rd, wr, wn;
    logic [7:0]  len;
    logic [31:0] addr;
    logic        e_rd, e_wr, e_wn, e_done;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_rdcmd = 0; cnt_valid = 0; cnt_done = 0; cnt_wracc = 0;
  endtask

  task automatic set_idle();
    in_rd = 0; in_wr = 0; ddr_valid = 0; ddr_wait_n = 1;
  endtask

  // Compare every output with the model at mid-cycle and tally events.
  task automatic sample_check();
    int          eff;
    logic        e_rd, e_wr, e_wn, e_val, e_done, e_busy;
    logic [31:0] e_addr;
    int          e_len;
    @(negedge clock);
    eff = (in_burstLength == 8'd0) ? 1 : int'(in_burstLength);
    if (m_left == 0) begin
      e_rd = in_rd; e_wr = in_wr && !in_rd; e_wn = ddr_wait_n; e_val = 0;
      e_done = !in_rd && in_wr && ddr_wait_n && (eff == 1);
      e_addr = in_addr / 32'd8; e_len = eff; e_busy = 0;
    end else if (m_is_rd) begin
      e_rd = 0; e_wr = 0; e_wn = 0; e_val = ddr_valid;
      e_done = ddr_valid && (m_left == 1);
      e_addr = m_addr / 32'd8; e_len = m_len; e_busy = 1;
    end else begin
      e_rd = 0; e_wr = in_wr; e_wn = ddr_wait_n; e_val = 0;
      e_done = in_wr && ddr_wait_n && (m_left == 1);
      e_addr = m_addr / 32'd8; e_len = m_len; e_busy = 1;
    end
    chk("ddr_rd", 64'(ddr_rd), 64'(e_rd));
    chk("ddr_wr", 64'(ddr_wr), 64'(e_wr));
    chk("in_wait_n", 64'(in_wait_n), 64'(e_wn));
    chk("in_valid", 64'(in_valid), 64'(e_val));
    chk("in_burstDone", 64'(in_burstDone), 64'(e_done));
    chk("ddr_addr", 64'(ddr_addr), 64'(e_addr));
    chk("ddr_burstLength", 64'(ddr_burstLength), 64'(e_len));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("err", 64'(err), 64'(m_err));
    chk("in_dout", in_dout, ddr_dout);
    chk("ddr_din", ddr_din, in_din);
    chk("ddr_mask", 64'(ddr_mask), 64'(in_mask));
    if (ddr_rd) cnt_rdcmd++;
    if (in_valid) cnt_valid++;
    if (in_burstDone) cnt_done++;
    if (ddr_wr && ddr_wait_n) cnt_wracc++;
  endtask

  // Advance the model across the rising edge.
  task automatic advance();
    int eff;
    @(posedge clock);
    eff = (in_burstLength == 8'd0) ? 1 : int'(in_burstLength);
    if (reset) begin
      m_left = 0; m_err = 0;
    end else begin
      if (ddr_valid && !(m_left > 0 && m_is_rd)) m_err = 1;
      if (m_left == 0) begin
        if (in_rd && ddr_wait_n) begin
          m_is_rd = 1; m_left = eff; m_addr = in_addr; m_len = eff;
        end else if (in_wr && ddr_wait_n && eff > 1) begin
          m_is_rd = 0; m_left = eff - 1; m_addr = in_addr; m_len = eff;
        end
      end else if (m_is_rd) begin
        if (ddr_valid) m_left--;
      end else if (in_wr && ddr_wait_n) begin
        m_left--;
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample_check();
    advance();
  endtask

  initial begin
    int c;
    reset = 1; set_idle();
    in_addr = '0; in_mask = 8'hFF; in_din = '0; in_burstLength = 8'd1; ddr_dout = '0;

    // IDLE decode applied while reset is held, so the FSM cannot leave IDLE.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd16, 32'h0000_1000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 8'd16};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'd16, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 8'd16};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'd4,  32'h0000_0018, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 8'd4};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'd1,  32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 8'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'd0,  32'h0000_0027, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 8'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'd1,  32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 8'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'd5,  32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1FFF_FFFF, 8'd5};
    for (int i = 0; i < 7; i++) begin
      in_rd = vecs[i].rd; in_wr = vecs[i].wr; ddr_wait_n = vecs[i].wn;
      in_burstLength = vecs[i].len; in_addr = vecs[i].addr;
      sample_check();
      chk("tbl_ddr_rd", 64'(ddr_rd), 64'(vecs[i].e_rd));
      chk("tbl_ddr_wr", 64'(ddr_wr), 64'(vecs[i].e_wr));
      chk("tbl_wait_n", 64'(in_wait_n), 64'(vecs[i].e_wn));
      chk("tbl_done", 64'(in_burstDone), 64'(vecs[i].e_done));
      chk("tbl_addr", 64'(ddr_addr), 64'(vecs[i].e_addr));
      chk("tbl_len", 64'(ddr_burstLength), 64'(vecs[i].e_len));
      advance();
    end

    // Reset state with quiet inputs.
    set_idle();
    sample_check();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_valid", 64'(in_valid), 64'd0);
    chk("rst_done", 64'(in_burstDone), 64'd0);
    chk("rst_ddr_rd", 64'(ddr_rd), 64'd0);
    chk("rst_ddr_wr", 64'(ddr_wr), 64'd0);
    advance();
    reset = 0;
    cyc();

    // Read burst of 16 at 0x1000 with random valid gaps.
    clear_counts();
    in_addr = 32'h0000_1000; in_burstLength = 8'd16; in_rd = 1;
    sample_check();
    chk("rd16_addr", 64'(ddr_addr), 64'h200);
    advance();
    in_rd = 0;
    c = 0;
    while (cnt_done == 0 && c < 400) begin
      ddr_valid = ($urandom_range(0, 2) != 0);
      ddr_dout = {$urandom, $urandom};
      in_addr = $urandom; in_burstLength = 8'($urandom);
      in_rd = 1'($urandom_range(0, 1));
      cyc();
      c++;
    end
    chk("rd16_done_seen", 64'(cnt_done), 64'd1);
    chk("rd16_cmd_cycles", 64'(cnt_rdcmd), 64'd1);
    chk("rd16_valids", 64'(cnt_valid), 64'd16);
    set_idle();
    sample_check();
    chk("rd16_busy_after", 64'(busy), 64'd0);
    advance();

    // Write burst of 64 with random stalls and scrambled inputs after the first beat.
    clear_counts();
    in_addr = 32'h0010_0000; in_burstLength = 8'd64; in_wr = 1;
    c = 0;
    while (cnt_done == 0 && c < 800) begin
      ddr_wait_n = ($urandom_range(0, 2) != 0);
      in_din = {$urandom, $urandom}; in_mask = 8'($urandom);
      if (cnt_wracc > 0) begin
        in_addr = $urandom; in_burstLength = 8'($urandom);
        in_rd = 1'($urandom_range(0, 1));
      end
      sample_check();
      if (cnt_wracc > 0 && busy) begin
        chk("wr64_addr_hold", 64'(ddr_addr), 64'h0002_0000);
        chk("wr64_len_hold", 64'(ddr_burstLength), 64'd64);
      end
      advance();
      c++;
    end
    chk("wr64_done_seen", 64'(cnt_done), 64'd1);
    chk("wr64_beats", 64'(cnt_wracc), 64'd64);
    set_idle();
    cyc();

    // Single-beat write: done on acceptance, never busy.
    in_wr = 1; in_burstLength = 8'd1; in_mask = 8'h0F; in_addr = 32'h40;
    sample_check();
    chk("w1_done", 64'(in_burstDone), 64'd1);
    chk("w1_mask", 64'(ddr_mask), 64'h0F);
    advance();
    set_idle();
    sample_check();
    chk("w1_busy", 64'(busy), 64'd0);
    advance();

    // Read wins over a simultaneous write.
    in_rd = 1; in_wr = 1; in_burstLength = 8'd2; in_addr = 32'h80;
    sample_check();
    chk("rw_ddr_rd", 64'(ddr_rd), 64'd1);
    chk("rw_ddr_wr", 64'(ddr_wr), 64'd0);
    advance();
    set_idle();
    sample_check();
    chk("rw_busy", 64'(busy), 64'd1);
    advance();
    ddr_valid = 1; cyc(); cyc();
    ddr_valid = 0; cyc();

    // Stray valid in IDLE sets sticky err.
    ddr_valid = 1;
    sample_check();
    chk("stray_in_valid", 64'(in_valid), 64'd0);
    advance();
    ddr_valid = 0;
    cyc(); cyc();
    sample_check();
    chk("stray_err_sticky", 64'(err), 64'd1);
    advance();

    // Reset mid-read, then late valids are stray.
    reset = 1; cyc(); reset = 0;
    in_rd = 1; in_burstLength = 8'd16; in_addr = 32'h1000; cyc();
    in_rd = 0; ddr_valid = 1;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1; ddr_valid = 0; cyc(); reset = 0;
    sample_check();
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_err", 64'(err), 64'd0);
    advance();
    ddr_valid = 1; cyc();
    ddr_valid = 0;
    sample_check();
    chk("rstmid_late_err", 64'(err), 64'd1);
    advance();

    // Length 0 write behaves as length 1.
    reset = 1; cyc(); reset = 0;
    in_wr = 1; in_burstLength = 8'd0;
    sample_check();
    chk("len0_done", 64'(in_burstDone), 64'd1);
    chk("len0_len", 64'(ddr_burstLength), 64'd1);
    advance();
    set_idle();
    sample_check();
    chk("len0_busy", 64'(busy), 64'd0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      in_rd = ($urandom_range(0, 5) == 0);
      in_wr = ($urandom_range(0, 2) == 0);
      ddr_wait_n = ($urandom_range(0, 3) != 0);
      ddr_valid = ($urandom_range(0, 2) == 0);
      in_burstLength = 8'($urandom_range(0, 4));
      in_addr = $urandom; in_mask = 8'($urandom);
      in_din = {$urandom, $urandom}; ddr_dout = {$urandom, $urandom};
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_burst_ctrl.md
# ddr_burst_ctrl

Sits directly downstream of the 3-port burst memory arbiter and upstream of the MiSTer DDR (Avalon-style) port. Tracks each granted burst, holds the burst length and address stable for the whole transaction, counts beats, and produces the `burstDone` strobe the arbiter needs to release its grant. It also converts byte addresses to 64-bit word addresses. It adds no data latency: all data and handshake paths are combinational pass-throughs, gated by a small FSM.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width on both sides.
- `LEN_W`, default 8: burst-length width.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `in_rd` in 1: read request from the arbiter.
- `in_wr` in 1: write beat from the arbiter.
- `in_addr` in ADDR_W: byte address; sampled on the first beat.
- `in_mask` in 8: byte enables.
- `in_din` in 64: write data.
- `in_burstLength` in LEN_W: beats in the burst; sampled on the first beat.
- `in_dout` out 64: read data.
- `in_wait_n` out 1: beat or command accepted when high.
- `in_valid` out 1: read-data strobe.
- `in_burstDone` out 1: last beat of the burst completes this cycle.
- `ddr_rd` out 1, `ddr_wr` out 1: DDR command and write strobes.
- `ddr_addr` out ADDR_W: word address, equal to `{3'b0, addr[ADDR_W-1:3]}`.
- `ddr_mask` out 8: byte enables to DDR.
- `ddr_din` out 64: write data to DDR.
- `ddr_burstLength` out LEN_W: burst length to DDR.
- `ddr_dout` in 64: read data from DDR.
- `ddr_wait_n` in 1: DDR not stalling.
- `ddr_valid` in 1: DDR read-data strobe.
- `busy` out 1: FSM not in IDLE.
- `err` out 1: sticky flag, set on any `ddr_valid` that arrives outside READ.

## Operation
- FSM states: IDLE, READ, WRITE. Beat counter `remain` is LEN_W bits wide. A burst length of 0 is treated as 1.
- IDLE:
  - `ddr_rd = in_rd`, `ddr_wr = in_wr & ~in_rd`. Read wins if both are asserted, and the write is not accepted that cycle.
  - Address and length pass through live. `in_wait_n = ddr_wait_n`.
  - Read accepted (`in_rd & ddr_wait_n`): latch address and length, set `remain = len`, go to READ.
  - Write accepted (`in_wr & ~in_rd & ddr_wait_n`):
    - If `len == 1`: assert `in_burstDone` this cycle and stay in IDLE.
    - Otherwise: latch address and length, set `remain = len - 1`, go to WRITE.
- READ:
  - `ddr_rd = 0`, `ddr_wr = 0`, `in_wait_n = 0`.
  - `in_valid = ddr_valid`; `in_dout = ddr_dout` in all states.
  - Each `ddr_valid` decrements `remain`. When `remain == 1` and `ddr_valid`: assert `in_burstDone` and go to IDLE.
- WRITE:
  - `ddr_wr = in_wr`, `in_wait_n = ddr_wait_n`. `ddr_addr` and `ddr_burstLength` come from the latched registers. `in_rd` is ignored.
  - Each accepted beat (`in_wr & ddr_wait_n`) decrements `remain`. When `remain == 1` and a beat is accepted: assert `in_burstDone` and go to IDLE.
- `in_valid` is driven only in READ. A `ddr_valid` in IDLE or WRITE is dropped and sets `err`; only `reset` clears `err`.
- Reset mid-burst: state goes to IDLE, `remain` to 0, `err` to 0. Read data still outstanding from DDR afterwards is treated as stray: it is dropped and sets `err`. This is the documented behaviour.

## Timing
- Reset values:
  - `busy` = 0, `err` = 0, `in_valid` = 0, `in_burstDone` = 0, `ddr_rd` = 0, `ddr_wr` = 0.
  - `in_wait_n` follows `ddr_wait_n`; address, length and data outputs follow their inputs.
- Zero-cycle latency in both directions:
  - Read data appears on `in_dout`/`in_valid` in the same cycle as `ddr_valid`.
  - `in_burstDone` is combinational, in the same cycle as the final accepted write beat or final read valid.
- State and counter update on the rising edge after the qualifying cycle. A new command can be accepted in the cycle immediately after `in_burstDone`.
- A single-beat write completes entirely in IDLE; `busy` never rises.
- A `ddr_wait_n` stall during WRITE freezes `remain`; the beat is retried.
- Read command to IDLE: exactly N `ddr_valid` cycles, with any gaps between them.

## Structure
- Package `ddr_burst_pkg`: `state_t` enum (IDLE, READ, WRITE), `LEN_W`, `WORD_SHIFT` = 3.
- One natural sub-module: `burst_counter`. It takes load/value/decrement inputs and produces the `last` flag (`remain == 1`). The FSM, latches and muxing stay in the top level.

## Test plan
- Read burst of 16 at byte address 0x0000_1000: `ddr_addr` = 0x200; one cycle with `ddr_rd` high; 16 valids with random gaps → 16 `in_valid`, `in_burstDone` on the 16th, `busy` low on the next cycle.
- Write burst of 64 at 0x0010_0000 with `ddr_wait_n` toggled randomly → exactly 64 `ddr_wr` beats accepted; `ddr_addr` and `ddr_burstLength` = 64 held through WRITE while `in_addr` is scrambled; `in_burstDone` on the last beat.
- Single write, length 1, mask 0x0F → `in_burstDone` in the same cycle as acceptance, `busy` stays 0, `ddr_mask` = 0x0F.
- `in_rd` and `in_wr` asserted together in IDLE → `ddr_rd` = 1, `ddr_wr` = 0, FSM goes to READ.
- Stray `ddr_valid` in IDLE → `in_valid` = 0 and `err` = 1 sticky. Then reset in the middle of a 16-beat read → IDLE; later valids raise `err` again.
- `in_burstLength` = 0 on a write → treated as 1: `in_burstDone` immediately, `ddr_burstLength` = 1.
